// File: rtl/uart_rx_gen2.sv
// UART receiver: majority-vote sampling, run-time frame format, break/timeout
// detection and a show-ahead receive FIFO holding {brk, fe, pe, data}.
module uart_rx_gen2 #(
    parameter int DATA_MAX   = 9,
    parameter int FIFO_DEPTH = 16,
    parameter int PTR_W      = 4,
    parameter int OSR        = 16,
    parameter int TMO_W      = 8
) (
    input  logic                pclk,
    input  logic                prst_n,
    input  logic                cfg_en,
    input  logic [2:0]          cfg_dlen,
    input  logic [1:0]          cfg_par,
    input  logic                cfg_stop2,
    input  logic [PTR_W:0]      cfg_thr,
    input  logic [TMO_W-1:0]    cfg_tmo,
    input  logic                fifo_flush,
    input  logic                ov_clr,
    input  logic                brg_tick,
    input  logic                uart_rx,
    input  logic                rd_en,
    output logic [DATA_MAX-1:0] rd_data,
    output logic                rd_pe,
    output logic                rd_fe,
    output logic                rd_brk,
    output logic                rx_busy,
    output logic                rx_empty,
    output logic                rx_full,
    output logic [PTR_W:0]      rx_level,
    output logic                rx_thr,
    output logic                rx_ov,
    output logic                rx_tmo
);
    localparam int CNT_W = $clog2(OSR);
    localparam int ENT_W = DATA_MAX + 3;
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP1  = 3'd4;
    localparam logic [2:0] ST_STOP2  = 3'd5;
    localparam logic [PTR_W:0] PTR_ONE = (PTR_W+1)'(1);

    logic                rx_meta_reg, rxs_reg, rxs_d_reg;
    logic [2:0]          state_reg;
    logic [CNT_W-1:0]    samp_cnt_reg;
    logic                samp_a_reg, samp_b_reg;
    logic [3:0]          bit_idx_reg;
    logic [DATA_MAX-1:0] data_reg;
    logic [2:0]          dlen_reg;
    logic [1:0]          par_reg;
    logic                stop2_reg, par_bit_reg, fe_reg;
    logic [PTR_W:0]      wptr_reg, rptr_reg;
    logic                ov_reg, tmo_flag_reg;
    logic [CNT_W-1:0]    tmo_tick_reg;
    logic [TMO_W-1:0]    tmo_cnt_reg;
    logic [ENT_W-1:0]    mem [FIFO_DEPTH];

    // Synchroniser and edge flop idle high so reset release is not a start edge
    always_ff @(posedge pclk or negedge prst_n) begin
        if (!prst_n) begin
            rx_meta_reg <= 1'b1;
            rxs_reg     <= 1'b1;
            rxs_d_reg   <= 1'b1;
        end else begin
            rx_meta_reg <= uart_rx;
            rxs_reg     <= rx_meta_reg;
            rxs_d_reg   <= rxs_reg;
        end
    end

    logic       start_edge, end_tick, vote_tick, vote, par_en, pe, fe_final, brk, push;
    logic [3:0] nbits;
    logic [2:0] dlen_clamp;
    assign start_edge = rxs_d_reg & ~rxs_reg;
    assign end_tick   = brg_tick & (samp_cnt_reg == CNT_W'(OSR-1));
    assign vote_tick  = brg_tick & (samp_cnt_reg == CNT_W'(OSR/2+1));
    assign vote       = (samp_a_reg & samp_b_reg) | (samp_a_reg & rxs_reg) | (samp_b_reg & rxs_reg);
    assign dlen_clamp = (cfg_dlen > 3'd4) ? 3'd4 : cfg_dlen;
    assign nbits      = 4'd5 + {1'b0, dlen_reg};
    assign par_en     = (par_reg == 2'b01) | (par_reg == 2'b10);
    assign pe         = par_en & (par_bit_reg ^ (^data_reg) ^ par_reg[1]);
    // fe_reg already holds the STOP1 result when the push happens in STOP2
    assign fe_final   = (state_reg == ST_STOP1) ? ~vote : (fe_reg | ~vote);
    assign brk        = (data_reg == '0) & (~par_en | ~par_bit_reg) &
                        ((state_reg == ST_STOP1) ? ~vote : fe_reg);
    assign push       = cfg_en & vote_tick &
                        (((state_reg == ST_STOP1) & ~stop2_reg) | (state_reg == ST_STOP2));

    always_ff @(posedge pclk or negedge prst_n) begin
        if (!prst_n) begin
            state_reg    <= ST_IDLE;
            samp_cnt_reg <= '0;
            samp_a_reg   <= 1'b1;
            samp_b_reg   <= 1'b1;
            bit_idx_reg  <= '0;
            data_reg     <= '0;
            dlen_reg     <= '0;
            par_reg      <= '0;
            stop2_reg    <= 1'b0;
            par_bit_reg  <= 1'b0;
            fe_reg       <= 1'b0;
        end else if (!cfg_en) begin
            state_reg    <= ST_IDLE;
            samp_cnt_reg <= '0;
            bit_idx_reg  <= '0;
        end else begin
            if (state_reg != ST_IDLE && brg_tick) begin
                samp_cnt_reg <= end_tick ? '0 : samp_cnt_reg + CNT_W'(1);
                if (samp_cnt_reg == CNT_W'(OSR/2-1)) samp_a_reg <= rxs_reg;
                if (samp_cnt_reg == CNT_W'(OSR/2))   samp_b_reg <= rxs_reg;
            end
            case (state_reg)
                ST_IDLE: if (start_edge) begin
                    state_reg    <= ST_START;
                    samp_cnt_reg <= '0;
                    dlen_reg     <= dlen_clamp;
                    par_reg      <= cfg_par;
                    stop2_reg    <= cfg_stop2;
                    data_reg     <= '0;
                    par_bit_reg  <= 1'b0;
                    fe_reg       <= 1'b0;
                end
                ST_START: if (vote_tick && vote) begin
                    state_reg    <= ST_IDLE;
                    samp_cnt_reg <= '0;
                end else if (end_tick) begin
                    state_reg   <= ST_DATA;
                    bit_idx_reg <= '0;
                end
                ST_DATA: begin
                    if (vote_tick) data_reg[bit_idx_reg] <= vote;
                    if (end_tick) begin
                        if (bit_idx_reg == nbits - 4'd1)
                            state_reg <= par_en ? ST_PARITY : ST_STOP1;
                        else
                            bit_idx_reg <= bit_idx_reg + 4'd1;
                    end
                end
                ST_PARITY: begin
                    if (vote_tick) par_bit_reg <= vote;
                    if (end_tick) state_reg <= ST_STOP1;
                end
                ST_STOP1: if (vote_tick) begin
                    fe_reg <= ~vote;
                    if (!stop2_reg) begin
                        state_reg    <= ST_IDLE;
                        samp_cnt_reg <= '0;
                    end
                end else if (end_tick) begin
                    state_reg <= ST_STOP2;
                end
                ST_STOP2: if (vote_tick) begin
                    state_reg    <= ST_IDLE;
                    samp_cnt_reg <= '0;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    logic [PTR_W:0]   level;
    logic             full, empty, pop, do_push, drop, start_go, tmo_active, tmo_clr;
    logic [ENT_W-1:0] head;
    assign level      = wptr_reg - rptr_reg;
    assign full       = (level == (PTR_W+1)'(FIFO_DEPTH));
    assign empty      = (level == '0);
    assign pop        = rd_en & ~empty;
    assign do_push    = push & (~full | pop);
    assign drop       = push & full & ~pop;
    assign start_go   = cfg_en & (state_reg == ST_IDLE) & start_edge;
    assign tmo_active = (state_reg == ST_IDLE) & ~empty & (cfg_tmo != '0);
    assign tmo_clr    = push | pop | start_go | fifo_flush;
    assign head       = mem[rptr_reg[PTR_W-1:0]];

    always_ff @(posedge pclk) begin
        if (do_push && !fifo_flush) mem[wptr_reg[PTR_W-1:0]] <= {brk, fe_final, pe, data_reg};
    end

    always_ff @(posedge pclk or negedge prst_n) begin
        if (!prst_n) begin
            wptr_reg <= '0;
            rptr_reg <= '0;
            ov_reg   <= 1'b0;
        end else if (fifo_flush) begin
            wptr_reg <= '0;
            rptr_reg <= '0;
            ov_reg   <= 1'b0;
        end else begin
            if (do_push) wptr_reg <= wptr_reg + PTR_ONE;
            if (pop)     rptr_reg <= rptr_reg + PTR_ONE;
            if (drop)        ov_reg <= 1'b1;
            else if (ov_clr) ov_reg <= 1'b0;
        end
    end

    // Idle timeout counts whole bit periods measured from the last FIFO/FSM event
    always_ff @(posedge pclk or negedge prst_n) begin
        if (!prst_n) begin
            tmo_tick_reg <= '0;
            tmo_cnt_reg  <= '0;
            tmo_flag_reg <= 1'b0;
        end else begin
            if (tmo_clr) begin
                tmo_tick_reg <= '0;
                tmo_cnt_reg  <= '0;
            end else if (tmo_active && brg_tick && tmo_cnt_reg < cfg_tmo) begin
                if (tmo_tick_reg == CNT_W'(OSR-1)) begin
                    tmo_tick_reg <= '0;
                    tmo_cnt_reg  <= tmo_cnt_reg + TMO_W'(1);
                end else begin
                    tmo_tick_reg <= tmo_tick_reg + CNT_W'(1);
                end
            end
            if (fifo_flush || pop)                           tmo_flag_reg <= 1'b0;
            else if (tmo_active && tmo_cnt_reg >= cfg_tmo)   tmo_flag_reg <= 1'b1;
        end
    end

    assign rd_data  = empty ? '0 : head[DATA_MAX-1:0];
    assign rd_pe    = ~empty & head[DATA_MAX];
    assign rd_fe    = ~empty & head[DATA_MAX+1];
    assign rd_brk   = ~empty & head[DATA_MAX+2];
    assign rx_busy  = (state_reg != ST_IDLE);
    assign rx_empty = empty;
    assign rx_full  = full;
    assign rx_level = level;
    assign rx_thr   = (cfg_thr != '0) & (level >= cfg_thr);
    assign rx_ov    = ov_reg;
    assign rx_tmo   = tmo_flag_reg;
endmodule

// File: tb/tb_uart_rx_gen2.sv
// Randomised and directed bench for uart_rx_gen2: serial frames are driven
// bit by bit and compared against a frame-level FIFO model kept in a queue.
module tb_uart_rx_gen2;
    localparam int DM = 9, FD = 16, PW = 4, OSR = 16, TW = 8;
    localparam int TDIV = 4, BIT_CYC = OSR * TDIV;

    logic          pclk = 1'b0, prst_n = 1'b0;
    logic          cfg_en, cfg_stop2, fifo_flush, ov_clr, brg_tick, uart_rx, rd_en;
    logic [2:0]    cfg_dlen;
    logic [1:0]    cfg_par;
    logic [PW:0]   cfg_thr;
    logic [TW-1:0] cfg_tmo;
    logic [DM-1:0] rd_data;
    logic          rd_pe, rd_fe, rd_brk, rx_busy, rx_empty, rx_full, rx_thr, rx_ov, rx_tmo;
    logic [PW:0]   rx_level;

    uart_rx_gen2 #(.DATA_MAX(DM), .FIFO_DEPTH(FD), .PTR_W(PW), .OSR(OSR), .TMO_W(TW)) dut (
        .pclk(pclk), .prst_n(prst_n), .cfg_en(cfg_en), .cfg_dlen(cfg_dlen), .cfg_par(cfg_par),
        .cfg_stop2(cfg_stop2), .cfg_thr(cfg_thr), .cfg_tmo(cfg_tmo), .fifo_flush(fifo_flush),
        .ov_clr(ov_clr), .brg_tick(brg_tick), .uart_rx(uart_rx), .rd_en(rd_en),
        .rd_data(rd_data), .rd_pe(rd_pe), .rd_fe(rd_fe), .rd_brk(rd_brk), .rx_busy(rx_busy),
        .rx_empty(rx_empty), .rx_full(rx_full), .rx_level(rx_level), .rx_thr(rx_thr),
        .rx_ov(rx_ov), .rx_tmo(rx_tmo)
    );

    always #5 pclk = ~pclk;

    initial begin
        int tdiv;
        tdiv = 0;
        brg_tick = 1'b0;
        forever begin
            @(negedge pclk);
            tdiv = (tdiv + 1) % TDIV;
            brg_tick = (tdiv == 0);
        end
    end

    int          n_tests = 0, n_fail = 0;
    logic [11:0] m_q[$];
    logic        m_ov = 1'b0;
    int          calib = -1;
    logic        busy_mid, busy_drop;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected FIFO entry for a frame, straight from the frame rules
    function automatic logic [11:0] model_entry(input logic [8:0] d, input int nb, input logic [1:0] par,
                                                input logic pbit, input logic s1, input logic s2, input logic st2);
        logic [8:0] dm;
        logic       pen, pe, fe, brk;
        dm  = 9'(int'(d) & ((1 << nb) - 1));
        pen = (par == 2'd1) || (par == 2'd2);
        pe  = pen && (pbit != ((^dm) ^ (par == 2'd2)));
        fe  = !s1 || (st2 && !s2);
        brk = (dm == 9'd0) && (!pen || !pbit) && !s1;
        return {brk, fe, pe, dm};
    endfunction

    task automatic model_push(input logic [11:0] e, input int act);
        if (act == 2) begin
            m_q.delete();
            m_ov = 1'b0;
        end else if (act == 1 && m_q.size() > 0) begin
            void'(m_q.pop_front());
            m_q.push_back(e);
        end else if (m_q.size() == FD) begin
            m_ov = 1'b1;
        end else begin
            m_q.push_back(e);
        end
    endtask

    task automatic align_tick();
        do @(posedge pclk); while (!brg_tick);
        #1;
    endtask

    // act: 0 plain, 1 rd_en at the push cycle, 2 fifo_flush at the push cycle, 3 drop cfg_en mid-data
    task automatic send_frame(input logic [8:0] d, input int dlen, input logic [1:0] par, input logic pbit,
                              input logic s1, input logic s2, input logic st2, input int glitch_bit,
                              input int act, input bit measure, input bit scramble);
        logic bits_a [0:15];
        int   nb, nbit;
        logic [PW:0] lvl0;
        nb = 5 + ((dlen > 4) ? 4 : dlen);
        bits_a[0] = 1'b0;
        for (int i = 0; i < nb; i++) bits_a[1+i] = d[i];
        nbit = 1 + nb;
        if (par == 2'd1 || par == 2'd2) begin bits_a[nbit] = pbit; nbit++; end
        bits_a[nbit] = s1; nbit++;
        if (st2) begin bits_a[nbit] = s2; nbit++; end
        cfg_dlen = 3'(dlen); cfg_par = par; cfg_stop2 = st2;
        align_tick();
        lvl0 = rx_level;
        for (int b = 0; b < nbit; b++) begin
            for (int c = 0; c < BIT_CYC; c++) begin
                uart_rx = (b == glitch_bit && c >= 32 && c < 32 + TDIV) ? ~bits_a[b] : bits_a[b];
                rd_en      = (b == nbit - 1) && (act == 1) && (c == calib);
                fifo_flush = (b == nbit - 1) && (act == 2) && (c == calib);
                if (act == 3 && b == 3 && c == 10) cfg_en = 1'b0;
                if (scramble && b == 2 && c == 0) begin
                    cfg_dlen = 3'($urandom_range(0, 7)); cfg_par = 2'($urandom_range(0, 3));
                    cfg_stop2 = 1'($urandom_range(0, 1));
                end
                @(posedge pclk); #1;
                if (b == 2 && c == 0) busy_mid = rx_busy;
                if (act == 3 && b == 3 && c == 20) busy_drop = rx_busy;
                if (measure && b == nbit - 1 && calib < 0 && rx_level != lvl0) calib = c;
            end
        end
        rd_en = 1'b0; fifo_flush = 1'b0; uart_rx = 1'b1; cfg_en = 1'b1;
        if (act != 3) model_push(model_entry(d, nb, par, pbit, s1, s2, st2), act);
        repeat (8) @(posedge pclk);
        #1;
    endtask

    task automatic check_head();
        @(negedge pclk);
        if (m_q.size() == 0) begin
            check_eq("empty", rx_empty, 1);
            check_eq("rd_zero", {rd_brk, rd_fe, rd_pe, rd_data}, 0);
        end else begin
            check_eq("head", {rd_brk, rd_fe, rd_pe, rd_data}, m_q[0]);
            check_eq("nonempty", rx_empty, 0);
        end
        check_eq("level", rx_level, m_q.size());
        check_eq("full", rx_full, m_q.size() == FD);
        check_eq("ov", rx_ov, m_ov);
        check_eq("thr", rx_thr, (cfg_thr != 0) && (m_q.size() >= int'(cfg_thr)));
    endtask

    task automatic do_pop();
        rd_en = 1'b1;
        @(posedge pclk); #1;
        rd_en = 1'b0;
        if (m_q.size() > 0) void'(m_q.pop_front());
    endtask

    task automatic drain();
        while (m_q.size() > 0) begin
            check_head();
            do_pop();
        end
        check_head();
    endtask

    initial begin
        logic [8:0] d, first_d;
        cfg_en = 1'b1; cfg_dlen = 3'd3; cfg_par = 2'd0; cfg_stop2 = 1'b0; cfg_thr = '0; cfg_tmo = '0;
        fifo_flush = 1'b0; ov_clr = 1'b0; uart_rx = 1'b1; rd_en = 1'b0;
        busy_mid = 1'b0; busy_drop = 1'b1;
        repeat (4) @(posedge pclk);
        @(negedge pclk);
        check_eq("rst_empty", rx_empty, 1);
        check_eq("rst_level", rx_level, 0);
        check_eq("rst_flags", {rx_busy, rx_full, rx_thr, rx_ov, rx_tmo}, 0);
        check_eq("rst_rd", {rd_brk, rd_fe, rd_pe, rd_data}, 0);
        #2 prst_n = 1'b1;
        repeat (4) @(posedge pclk);
        #1;

        // 8N1 0xA5, also calibrates the push cycle within the stop bit
        send_frame(9'h0A5, 3, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, -1, 0, 1'b1, 1'b0);
        check_eq("calib_found", calib >= 0, 1);
        check_eq("busy_mid", busy_mid, 1);
        check_eq("a5_data", rd_data, 9'h0A5);
        drain();
        do_pop();
        check_head();

        // 9-bit odd parity, good then bad parity bit; 7E2 with bad second stop
        send_frame(9'h1FF, 4, 2'd2, 1'b0, 1'b1, 1'b1, 1'b0, -1, 0, 1'b0, 1'b0);
        check_eq("odd_pe0", rd_pe, 0);
        drain();
        send_frame(9'h1FF, 4, 2'd2, 1'b1, 1'b1, 1'b1, 1'b0, -1, 0, 1'b0, 1'b0);
        check_eq("odd_pe1", {rd_pe, rd_data}, {1'b1, 9'h1FF});
        drain();
        send_frame(9'h05B, 2, 2'd1, 1'b1, 1'b1, 1'b0, 1'b1, -1, 0, 1'b0, 1'b0);
        check_eq("7e2_fe", rd_fe, 1);
        drain();

        // Short low pulse is a false start
        cfg_dlen = 3'd3; cfg_par = 2'd0; cfg_stop2 = 1'b0;
        align_tick();
        uart_rx = 1'b0;
        repeat (4 * TDIV) @(posedge pclk);
        #1;
        uart_rx = 1'b1;
        check_eq("noise_busy", rx_busy, 1);
        repeat (200) @(posedge pclk);
        #1;
        check_eq("noise_idle", rx_busy, 0);
        check_head();

        // One-tick glitches inside data bits
        send_frame(9'h03C, 3, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 4, 0, 1'b0, 1'b0);
        send_frame(9'h0C3, 3, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 2, 0, 1'b0, 1'b0);
        drain();

        // Break: 12 bit times low
        align_tick();
        uart_rx = 1'b0;
        repeat (12 * BIT_CYC) @(posedge pclk);
        #1;
        check_eq("brk_level", rx_level, 1);
        check_eq("brk_entry", {rd_brk, rd_fe, rd_pe, rd_data}, 12'hC00);
        m_q.push_back(12'hC00);
        uart_rx = 1'b1;
        repeat (2 * BIT_CYC) @(posedge pclk);
        #1;
        check_head();
        drain();

        // Overflow with 17 frames
        first_d = 9'h0;
        for (int i = 0; i < FD + 1; i++) begin
            d = 9'($urandom_range(0, 255));
            if (i == 0) first_d = d;
            send_frame(d, 3, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, -1, 0, 1'b0, 1'b0);
        end
        check_head();
        check_eq("ovf_state", {rx_full, rx_ov, rx_level}, {1'b1, 1'b1, 5'd16});
        check_eq("ovf_first", rd_data, first_d);
        ov_clr = 1'b1;
        @(posedge pclk); #1;
        ov_clr = 1'b0;
        m_ov = 1'b0;
        check_eq("ov_clr", rx_ov, 0);
        send_frame(9'h0E7, 3, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, -1, 1, 1'b0, 1'b0);
        check_eq("full_pop_push", {rx_ov, rx_level}, {1'b0, 5'd16});
        check_head();
        send_frame(9'h011, 3, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, -1, 0, 1'b0, 1'b0);
        check_head();
        repeat (3) do_pop();
        send_frame(9'h022, 3, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, -1, 2, 1'b0, 1'b0);
        check_eq("flush_push", {rx_ov, rx_level}, 0);
        check_head();

        // Idle timeout of 4 bit periods (64 ticks after the push)
        cfg_tmo = 8'd4;
        send_frame(9'h05A, 3, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, -1, 0, 1'b0, 1'b0);
        repeat (40 * TDIV) @(posedge pclk);
        #1;
        check_eq("tmo_early", rx_tmo, 0);
        repeat (20 * TDIV) @(posedge pclk);
        #1;
        check_eq("tmo_set", rx_tmo, 1);
        do_pop();
        check_eq("tmo_pop", rx_tmo, 0);
        cfg_tmo = 8'd0;
        check_head();

        // Receiver disabled mid-data: frame discarded
        send_frame(9'h0AA, 3, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, -1, 3, 1'b0, 1'b0);
        check_eq("en_drop_busy", busy_drop, 0);
        check_head();
        do_pop();
        check_head();

        // Randomised frames against the model
        for (int i = 0; i < 24; i++) begin
            int         dl, nb;
            logic [1:0] pr;
            logic       st2, s1, s2, pbit;
            logic [8:0] dm;
            dl  = $urandom_range(0, 7);
            nb  = 5 + ((dl > 4) ? 4 : dl);
            pr  = 2'($urandom_range(0, 3));
            st2 = 1'($urandom_range(0, 1));
            d   = 9'($urandom_range(0, 511));
            s1  = ($urandom_range(0, 6) != 0);
            s2  = ($urandom_range(0, 6) != 0);
            dm  = 9'(int'(d) & ((1 << nb) - 1));
            if (!s1 && dm == 9'd0) d = d | 9'd1;
            pbit = (^dm) ^ (pr == 2'd2) ^ ($urandom_range(0, 3) == 0);
            cfg_thr = 5'($urandom_range(0, 16));
            send_frame(d, dl, pr, pbit, s1, s2, st2,
                       ($urandom_range(0, 1) != 0) ? $urandom_range(0, 12) : -1, 0, 1'b0, 1'b1);
            check_head();
            repeat ($urandom_range(0, 2)) begin
                do_pop();
                check_head();
            end
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
